smul_sequencer: RTL and testbench

Multi-cycle multiply controller for the MiniALU datapath. It executes the `MUL4bits` and `SMUL` instructions iteratively instead of combinationally: it latches the operands, steps a shift-add or radix-2 Booth loop over a single adder, stalls instruction fetch while busy, and sequences the register-file write-back. For `SMUL` the low word goes to the destination register and the high word goes to R8.

---
 rtl/smul_sequencer_pkg.sv | 28 ++
 rtl/smul_sequencer_if.sv | 28 ++
 rtl/smul_sequencer_booth_step.sv | 47 ++++
 rtl/smul_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_smul_sequencer.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/smul_sequencer_pkg.sv
// Shared definitions for the iterative multiply sequencer: FSM encodings,
// mode constants, defaults and the iteration-count helper.
package smul_sequencer_pkg;

    typedef enum logic [1:0] {
        SMS_IDLE  = 2'd0,
        SMS_RUN   = 2'd1,
        SMS_WR_LO = 2'd2,
        SMS_WR_HI = 2'd3
    } sms_state_t;

    localparam logic MODE_MUL4 = 1'b0;
    localparam logic MODE_SMUL = 1'b1;

    localparam logic [7:0] HIGH_REG_DEFAULT   = 8'd8;
    localparam int         SMS_DEFAULT_WIDTH  = 16;
    localparam int unsigned MUL4_ITERATIONS   = 32'd4;

    // Number of RUN cycles for a given mode: one per multiplier bit.
    function automatic int unsigned iter_count(input logic mode, input int unsigned width);
        if (mode == MODE_SMUL) begin
            return width;
        end else begin
            return MUL4_ITERATIONS;
        end
    endfunction

endpackage

// File: rtl/smul_sequencer_if.sv
// Decode-to-sequencer request and register-file write-back bundle.
interface smul_sequencer_if
    import smul_sequencer_pkg::*;
#(
    parameter int WIDTH = SMS_DEFAULT_WIDTH
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [7:0]       dest;
    logic             busy;
    logic             stall;
    logic             write_enable;
    logic [7:0]       write_addr;
    logic [WIDTH-1:0] write_data;
    logic             done;

    modport master (
        output start, mode, a, b, dest,
        input  busy, stall, write_enable, write_addr, write_data, done
    );

    modport slave (
        input  start, mode, a, b, dest,
        output busy, stall, write_enable, write_addr, write_data, done
    );
endinterface

// File: rtl/smul_sequencer_booth_step.sv
// One iteration of the multiply loop: unsigned shift-add for MUL4bits,
// radix-2 Booth recoding with arithmetic shift for SMUL.
module booth_step
    import smul_sequencer_pkg::*;
#(
    parameter int WIDTH = SMS_DEFAULT_WIDTH
)
(
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] q,
    input  logic             q_m1,
    input  logic [WIDTH-1:0] a,
    input  logic             mode,
    output logic [WIDTH:0]   acc_next,
    output logic [WIDTH-1:0] q_next,
    output logic             q_m1_next
);

    logic [WIDTH:0] sum_s;

    // Conditional add/subtract followed by the one-bit right shift of {acc, Q, q(-1)}.
    always_comb begin
        sum_s     = acc;
        acc_next  = acc;
        q_next    = q;
        q_m1_next = q_m1;
        if (mode == MODE_MUL4) begin
            if (q[0]) begin
                sum_s = acc + {{(WIDTH-3){1'b0}}, a[3:0]};
            end else begin
                sum_s = acc;
            end
            acc_next = {1'b0, sum_s[WIDTH:1]};
        end else begin
            case ({q[0], q_m1})
                2'b01:   sum_s = acc + {a[WIDTH-1], a};
                2'b10:   sum_s = acc - {a[WIDTH-1], a};
                default: sum_s = acc;
            endcase
            // Accumulator is one bit wider than the operand so -(-2^(W-1)) fits.
            acc_next = {sum_s[WIDTH], sum_s[WIDTH:1]};
        end
        q_next    = {sum_s[0], q[WIDTH-1:1]};
        q_m1_next = q[0];
    end

endmodule

// File: rtl/smul_sequencer.sv
// Multi-cycle multiply controller: latches operands, iterates booth_step over
// a single adder, stalls fetch while busy and sequences register write-back.
module smul_sequencer
    import smul_sequencer_pkg::*;
#(
    parameter logic [7:0] HIGH_REG = HIGH_REG_DEFAULT,
    parameter int         WIDTH    = SMS_DEFAULT_WIDTH
)
(
    input  logic              clk,
    input  logic              rst,
    smul_sequencer_if.slave   bus
);

    localparam int CW = $clog2(WIDTH + 1);

    sms_state_t       state_r;
    sms_state_t       state_s;

    logic [WIDTH:0]   acc_r;
    logic [WIDTH:0]   acc_s;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_s;
    logic             q_m1_r;
    logic             q_m1_s;
    logic [WIDTH-1:0] a_r;
    logic             mode_r;
    logic [7:0]       dest_r;
    logic [CW-1:0]    count_r;
    logic             last_iter_s;

    logic             busy_r;
    logic             busy_s;
    logic             we_r;
    logic             we_s;
    logic [7:0]       waddr_r;
    logic [7:0]       waddr_s;
    logic [WIDTH-1:0] wdata_r;
    logic [WIDTH-1:0] wdata_s;
    logic             done_r;
    logic             done_s;

    booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc       (acc_r),
        .q         (q_r),
        .q_m1      (q_m1_r),
        .a         (a_r),
        .mode      (mode_r),
        .acc_next  (acc_s),
        .q_next    (q_s),
        .q_m1_next (q_m1_s)
    );

    assign last_iter_s = (count_r == CW'(1'b1));

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= SMS_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; starts are only honoured in IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            SMS_IDLE: begin
                if (bus.start) begin
                    state_s = SMS_RUN;
                end else begin
                    state_s = SMS_IDLE;
                end
            end
            SMS_RUN: begin
                if (last_iter_s) begin
                    state_s = SMS_WR_LO;
                end else begin
                    state_s = SMS_RUN;
                end
            end
            SMS_WR_LO: begin
                if (mode_r == MODE_SMUL) begin
                    state_s = SMS_WR_HI;
                end else begin
                    state_s = SMS_IDLE;
                end
            end
            SMS_WR_HI: state_s = SMS_IDLE;
            default:   state_s = SMS_IDLE;
        endcase
    end

    // Next values of the registered outputs, keyed on the state being entered so
    // the write strobe lines up with the cycle spent in that write state.
    always_comb begin
        busy_s  = (state_s != SMS_IDLE);
        we_s    = 1'b0;
        waddr_s = 8'd0;
        wdata_s = '0;
        done_s  = 1'b0;
        case (state_s)
            SMS_WR_LO: begin
                we_s    = 1'b1;
                waddr_s = dest_r;
                if (mode_r == MODE_SMUL) begin
                    wdata_s = q_s;
                    done_s  = 1'b0;
                end else begin
                    // 8-bit product: high nibble in acc, low nibble shifted into Q's top.
                    wdata_s = {{(WIDTH-8){1'b0}}, acc_s[3:0], q_s[WIDTH-1 -: 4]};
                    done_s  = 1'b1;
                end
            end
            SMS_WR_HI: begin
                we_s    = 1'b1;
                waddr_s = HIGH_REG;
                wdata_s = acc_r[WIDTH-1:0];
                done_s  = 1'b1;
            end
            default: begin
                we_s    = 1'b0;
                waddr_s = 8'd0;
                wdata_s = '0;
                done_s  = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r  <= 1'b0;
            we_r    <= 1'b0;
            waddr_r <= 8'd0;
            wdata_r <= '0;
            done_r  <= 1'b0;
        end else begin
            busy_r  <= busy_s;
            we_r    <= we_s;
            waddr_r <= waddr_s;
            wdata_r <= wdata_s;
            done_r  <= done_s;
        end
    end

    // Operand latch and iteration datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r   <= '0;
            q_r     <= '0;
            q_m1_r  <= 1'b0;
            a_r     <= '0;
            mode_r  <= MODE_MUL4;
            dest_r  <= 8'd0;
            count_r <= '0;
        end else begin
            case (state_r)
                SMS_IDLE: begin
                    if (bus.start) begin
                        a_r     <= bus.a;
                        mode_r  <= bus.mode;
                        dest_r  <= bus.dest;
                        acc_r   <= '0;
                        q_m1_r  <= 1'b0;
                        count_r <= CW'(iter_count(bus.mode, WIDTH));
                        if (bus.mode == MODE_SMUL) begin
                            q_r <= bus.b;
                        end else begin
                            q_r <= {{(WIDTH-4){1'b0}}, bus.b[3:0]};
                        end
                    end
                end
                SMS_RUN: begin
                    acc_r   <= acc_s;
                    q_r     <= q_s;
                    q_m1_r  <= q_m1_s;
                    count_r <= count_r - CW'(1'b1);
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    assign bus.busy         = busy_r;
    assign bus.stall        = bus.start | busy_r;
    assign bus.write_enable = we_r;
    assign bus.write_addr   = waddr_r;
    assign bus.write_data   = wdata_r;
    assign bus.done         = done_r;

endmodule

// File: tb/tb_smul_sequencer.sv
// Scoreboard bench: stimulus pushes expected register writes, a monitor thread
// pops and compares them whenever the sequencer strobes a write.
module tb_smul_sequencer;
    import smul_sequencer_pkg::*;

    localparam int W = 16;

    typedef struct {
        logic [7:0]   addr;
        logic [W-1:0] data;
        logic         done;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    wr_t  exp_q[$];

    always #5 clk = ~clk;

    smul_sequencer_if #(.WIDTH(W)) bus();

    smul_sequencer #(
        .HIGH_REG (8'd8),
        .WIDTH    (W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; pulses start for one cycle and optionally records the expected writes.
    task automatic start_op(input logic mode, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [7:0] dest, input logic [W-1:0] lo,
                            input logic [W-1:0] hi, input bit push);
        wr_t w;
        if (push) begin
            w.addr = dest; w.data = lo; w.done = (mode == MODE_MUL4);
            exp_q.push_back(w);
            if (mode == MODE_SMUL) begin
                w.addr = 8'd8; w.data = hi; w.done = 1'b1;
                exp_q.push_back(w);
            end
        end
        bus.start = 1'b1; bus.mode = mode; bus.a = a; bus.b = b; bus.dest = dest;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Counts remaining busy cycles from the current negedge; bounded.
    task automatic wait_idle(input string name, input int exp_cycles);
        int n = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            check("stall_while_busy", {31'd0, bus.stall}, 32'd1);
            n++;
            @(negedge clk);
        end
        check(name, n, exp_cycles);
    endtask

    initial begin
        fork
            forever begin
                @(posedge clk);
                #1;
                if (bus.write_enable === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: addr=%0h data=%0h with nothing expected",
                                 bus.write_addr, bus.write_data);
                    end else begin
                        wr_t e;
                        e = exp_q.pop_front();
                        check("write_addr", {24'd0, bus.write_addr}, {24'd0, e.addr});
                        check("write_data", {16'd0, bus.write_data}, {16'd0, e.data});
                        check("write_done", {31'd0, bus.done}, {31'd0, e.done});
                    end
                end else if (bus.done !== 1'b0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_without_write: done=%b write_enable=%b", bus.done, bus.write_enable);
                end
            end
        join_none

        rst = 1'b1;
        bus.start = 1'b1; bus.mode = 1'b0; bus.a = '0; bus.b = '0; bus.dest = 8'd0;
        repeat (2) @(negedge clk);
        check("rst_busy",  {31'd0, bus.busy}, 32'd0);
        check("rst_we",    {31'd0, bus.write_enable}, 32'd0);
        check("rst_addr",  {24'd0, bus.write_addr}, 32'd0);
        check("rst_data",  {16'd0, bus.write_data}, 32'd0);
        check("rst_done",  {31'd0, bus.done}, 32'd0);
        check("rst_stall_start1", {31'd0, bus.stall}, 32'd1);
        bus.start = 1'b0;
        #1;
        check("rst_stall_start0", {31'd0, bus.stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        start_op(MODE_MUL4, 16'h0002, 16'h0004, 8'd5, 16'h0008, 16'h0000, 1'b1);
        wait_idle("busy_mul4_basic", 5);
        start_op(MODE_MUL4, 16'hFF3F, 16'h000F, 8'd5, 16'h00E1, 16'h0000, 1'b1);
        wait_idle("busy_mul4_mask", 5);
        start_op(MODE_SMUL, 16'hFFFE, 16'h0008, 8'd5, 16'hFFF0, 16'hFFFF, 1'b1);
        wait_idle("busy_smul_neg", 18);
        start_op(MODE_SMUL, 16'h8000, 16'h8000, 8'd5, 16'h0000, 16'h4000, 1'b1);
        wait_idle("busy_smul_min_min", 18);
        start_op(MODE_SMUL, 16'h8000, 16'h7FFF, 8'd5, 16'h8000, 16'hC000, 1'b1);
        wait_idle("busy_smul_min_max", 18);
        start_op(MODE_SMUL, 16'h7FFF, 16'h7FFF, 8'd5, 16'h0001, 16'h3FFF, 1'b1);
        wait_idle("busy_smul_max_max", 18);
        start_op(MODE_SMUL, 16'h0003, 16'h0005, 8'd8, 16'h000F, 16'h0000, 1'b1);
        wait_idle("busy_dest_r8", 18);

        // Second start mid-RUN must be ignored.
        start_op(MODE_SMUL, 16'h0003, 16'h0004, 8'd6, 16'h000C, 16'h0000, 1'b1);
        repeat (2) @(negedge clk);
        bus.start = 1'b1; bus.mode = MODE_MUL4; bus.a = 16'h1234; bus.b = 16'h5678; bus.dest = 8'd9;
        check("stall_during_restart", {31'd0, bus.stall}, 32'd1);
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle("busy_after_ignored_start", 15);

        // Reset on the 8th RUN cycle discards the product.
        start_op(MODE_SMUL, 16'h1111, 16'h2222, 8'd7, 16'h0000, 16'h0000, 1'b0);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_we",   {31'd0, bus.write_enable}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy_after", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        start_op(MODE_SMUL, 16'hFFFF, 16'hFFFF, 8'd7, 16'h0001, 16'h0000, 1'b1);
        wait_idle("busy_after_reset", 18);

        repeat (3) @(negedge clk);
        check("pending_writes", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
